// File: rtl/bias_bank_adder_pkg.sv
// -----------------------------------------------------------------------------
// bias_bank_adder_pkg
//   Shared constants and helpers for the bias bank adder.
//   - DATA_W          : default signed lane width
//   - lane_lsb()      : bit offset of lane k inside a packed row
//   - sat_hi/sat_lo() : saturation bounds for a given lane width
//   - SAT_MAX/SAT_MIN : saturation bounds at the default lane width
// -----------------------------------------------------------------------------
package bias_bank_adder_pkg;

    localparam int DATA_W = 18;

    // Lane k of a packed row lives at bits [width*(k+1)-1 : width*k].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Largest positive value of a width-bit two's-complement number,
    // returned zero-extended to 64 bits; truncate to width at the use site.
    function automatic logic [63:0] sat_hi(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative value of a width-bit two's-complement number; its low
    // width bits are 1000...0.
    function automatic logic [63:0] sat_lo(input int width);
        return ~sat_hi(width);
    endfunction

    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_hi(DATA_W));
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_lo(DATA_W));

endpackage

// File: rtl/bias_sat_lane.sv
// -----------------------------------------------------------------------------
// bias_sat_lane
//   One output channel: signed add of accumulator and bias at DATA_W+1 bits,
//   saturation back to DATA_W bits, optional ReLU clamp. Purely combinational.
// Ports:
//   in_lane   : accumulator value (signed, DATA_W)
//   bias_lane : bias value (signed, DATA_W)
//   relu_en   : clamp negative results to zero
//   out_lane  : biased, saturated, optionally clamped result
// -----------------------------------------------------------------------------
module bias_sat_lane #(
    parameter int DATA_W = bias_bank_adder_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] in_lane,
    input  logic [DATA_W-1:0] bias_lane,
    input  logic              relu_en,
    output logic [DATA_W-1:0] out_lane
);
    import bias_bank_adder_pkg::*;

    localparam logic [DATA_W-1:0] LANE_HI = DATA_W'(sat_hi(DATA_W));
    localparam logic [DATA_W-1:0] LANE_LO = DATA_W'(sat_lo(DATA_W));

    logic [DATA_W:0]   sum;
    logic              overflow;
    logic [DATA_W-1:0] sat;

    // NOTE: every signal written here gets a value on every path, so no
    // latch is inferred even though the saturation logic branches.
    always_comb begin
        // Sign-extend both operands by one bit so the sum cannot wrap.
        sum      = {in_lane[DATA_W-1], in_lane} + {bias_lane[DATA_W-1], bias_lane};
        // The two top bits disagree only when the true result is outside the
        // DATA_W-bit range; the extra top bit then carries the real sign.
        overflow = sum[DATA_W] ^ sum[DATA_W-1];
        if (overflow) begin
            sat = sum[DATA_W] ? LANE_LO : LANE_HI;
        end else begin
            sat = sum[DATA_W-1:0];
        end
        out_lane = (relu_en && sat[DATA_W-1]) ? '0 : sat;
    end

endmodule

// File: rtl/bias_bank_adder.sv
// -----------------------------------------------------------------------------
// bias_bank_adder
//   Adds a per-group bias row to each incoming beat of N_LANES accumulator
//   values, saturates each lane and optionally applies ReLU. The group pointer
//   walks 0..cfg_groups-1 over successive beats, so consecutive beats pick up
//   consecutive bias rows. One register stage with a valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_groups, cfg_relu  : group count and ReLU enable, latched on grp_clr
//   grp_clr               : restart the group pointer at 0 and latch config
//   ld_valid/addr/data    : bias row write port
//   in_valid/ready/data   : accumulator input stream
//   out_valid/ready/data  : biased output stream
//   out_grp               : group index used for the current output beat
//   grp_wrap              : pulses when the last group's beat is accepted
// -----------------------------------------------------------------------------
module bias_bank_adder #(
    parameter int N_LANES  = 16,
    parameter int DATA_W   = bias_bank_adder_pkg::DATA_W,
    parameter int N_GROUPS = 8,
    parameter int GRP_W    = $clog2(N_GROUPS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [GRP_W:0]              cfg_groups,
    input  logic                        cfg_relu,
    input  logic                        grp_clr,
    input  logic                        ld_valid,
    input  logic [GRP_W-1:0]            ld_addr,
    input  logic [N_LANES*DATA_W-1:0]   ld_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LANES*DATA_W-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANES*DATA_W-1:0]   out_data,
    output logic [GRP_W-1:0]            out_grp,
    output logic                        grp_wrap
);
    import bias_bank_adder_pkg::*;

    localparam int             ROW_W      = N_LANES * DATA_W;
    localparam logic [GRP_W:0] GROUPS_MAX = (GRP_W + 1)'(N_GROUPS);

    // Bias bank and latched configuration
    logic [ROW_W-1:0] bias_q [N_GROUPS];
    logic [ROW_W-1:0] bias_d [N_GROUPS];
    logic [GRP_W:0]   groups_q, groups_d;
    logic             relu_q, relu_d;
    logic [GRP_W-1:0] grp_ptr_q, grp_ptr_d;

    // Output stage
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_data_q, out_data_d;
    logic [GRP_W-1:0] out_grp_q, out_grp_d;

    logic             in_accept;
    logic             ptr_at_last;
    logic [ROW_W-1:0] bias_row;
    logic [ROW_W-1:0] lane_result;

    // The output register can take a new beat when empty or draining now.
    assign in_ready    = !out_valid_q || out_ready;
    assign in_accept   = in_valid && in_ready;
    assign ptr_at_last = ({1'b0, grp_ptr_q} == (groups_q - 1'b1));
    assign grp_wrap    = in_accept && ptr_at_last;

    // Reading the registered bank means a row written this cycle is seen
    // only by later beats.
    assign bias_row = bias_q[grp_ptr_q];

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        bias_sat_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .in_lane   (in_data[lane_lsb(k, DATA_W) +: DATA_W]),
            .bias_lane (bias_row[lane_lsb(k, DATA_W) +: DATA_W]),
            .relu_en   (relu_q),
            .out_lane  (lane_result[lane_lsb(k, DATA_W) +: DATA_W])
        );
    end

    always_comb begin
        // Bias bank write; addresses beyond the bank are dropped.
        bias_d = bias_q;
        if (ld_valid && (int'(ld_addr) < N_GROUPS)) begin
            bias_d[ld_addr] = ld_data;
        end

        // Configuration; an out-of-range group count means "use them all".
        groups_d = groups_q;
        relu_d   = relu_q;
        if (grp_clr) begin
            if ((cfg_groups == '0) || (cfg_groups > GROUPS_MAX)) begin
                groups_d = GROUPS_MAX;
            end else begin
                groups_d = cfg_groups;
            end
            relu_d = cfg_relu;
        end

        // A clear wins over an advance; the beat accepted alongside a clear
        // has already used the old pointer through bias_row.
        grp_ptr_d = grp_ptr_q;
        if (grp_clr) begin
            grp_ptr_d = '0;
        end else if (in_accept) begin
            grp_ptr_d = ptr_at_last ? '0 : grp_ptr_q + 1'b1;
        end

        // Output stage: load on accept, otherwise hold until drained.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_grp_d   = out_grp_q;
        if (in_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_result;
            out_grp_d   = grp_ptr_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of its _d input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the bias bank is cleared on reset so a stream started
            // right after reset adds zero instead of stale rows; this keeps
            // the bank in flops rather than a RAM macro.
            for (int g = 0; g < N_GROUPS; g++) begin
                bias_q[g] <= '0;
            end
            groups_q    <= GROUPS_MAX;
            relu_q      <= 1'b0;
            grp_ptr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grp_q   <= '0;
        end else begin
            bias_q      <= bias_d;
            groups_q    <= groups_d;
            relu_q      <= relu_d;
            grp_ptr_q   <= grp_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_grp_q   <= out_grp_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grp   = out_grp_q;

endmodule

// File: tb/tb_bias_bank_adder.sv
// -----------------------------------------------------------------------------
// tb_bias_bank_adder
//   Self-checking bench for bias_bank_adder: a table of single-beat arithmetic
//   vectors, directed multi-cycle sequences, and a randomised stream, all
//   cross-checked against a scoreboard fed by a cycle model at each negedge.
// -----------------------------------------------------------------------------
module tb_bias_bank_adder;

    localparam int N_LANES  = 16;
    localparam int DATA_W   = 18;
    localparam int N_GROUPS = 8;
    localparam int GRP_W    = 3;
    localparam int ROW_W    = N_LANES * DATA_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [GRP_W:0]      cfg_groups;
    logic                cfg_relu;
    logic                grp_clr;
    logic                ld_valid;
    logic [GRP_W-1:0]    ld_addr;
    logic [ROW_W-1:0]    ld_data;
    logic                in_valid;
    logic                in_ready;
    logic [ROW_W-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [ROW_W-1:0]    out_data;
    logic [GRP_W-1:0]    out_grp;
    logic                grp_wrap;

    int n_checks = 0;
    int n_errors = 0;

    bias_bank_adder #(
        .N_LANES  (N_LANES),
        .DATA_W   (DATA_W),
        .N_GROUPS (N_GROUPS),
        .GRP_W    (GRP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_groups (cfg_groups),
        .cfg_relu   (cfg_relu),
        .grp_clr    (grp_clr),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_grp    (out_grp),
        .grp_wrap   (grp_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [ROW_W-1:0] model_row(input logic [ROW_W-1:0] din,
                                                   input logic [ROW_W-1:0] bias,
                                                   input logic relu);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_LANES; k++) begin
            int a;
            int b;
            int s;
            a = int'($signed(din[k*DATA_W +: DATA_W]));
            b = int'($signed(bias[k*DATA_W +: DATA_W]));
            s = a + b;
            if (s > 131071) s = 131071;
            if (s < -131072) s = -131072;
            if (relu && s < 0) s = 0;
            r[k*DATA_W +: DATA_W] = DATA_W'(s);
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rep(input logic [DATA_W-1:0] v);
        return {N_LANES{v}};
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < N_LANES; k++) begin
            r[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
        return r;
    endfunction

    typedef struct {
        logic [ROW_W-1:0] data;
        logic [GRP_W-1:0] grp;
    } exp_t;

    exp_t             sb[$];
    logic [ROW_W-1:0] m_bias [N_GROUPS];
    int               m_groups;
    logic             m_relu;
    int               m_ptr;
    logic             m_out_valid;
    logic             m_in_ready;
    logic             m_acc;
    logic             m_last;
    exp_t             m_item;

    // Cycle model: checks the DUT outputs of the current cycle, then advances
    // its own state by what the coming rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < N_GROUPS; g++) m_bias[g] = '0;
            m_groups    = N_GROUPS;
            m_relu      = 1'b0;
            m_ptr       = 0;
            m_out_valid = 1'b0;
            sb.delete();
        end else begin
            m_in_ready = !m_out_valid || out_ready;
            m_acc      = in_valid && m_in_ready;
            m_last     = m_acc && (m_ptr == m_groups - 1);
            check("mon_in_ready", in_ready, m_in_ready);
            check("mon_out_valid", out_valid, m_out_valid);
            check("mon_grp_wrap", grp_wrap, m_last);
            if (m_out_valid) begin
                if (sb.size() == 0) begin
                    check("mon_sb_empty", 1'b1, 1'b0);
                end else begin
                    check("mon_out_data", out_data, sb[0].data);
                    check("mon_out_grp", out_grp, sb[0].grp);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (m_acc) begin
                m_item.data = model_row(in_data, m_bias[m_ptr], m_relu);
                m_item.grp  = GRP_W'(m_ptr);
                sb.push_back(m_item);
            end
            m_out_valid = m_acc || (m_out_valid && !out_ready);
            if (grp_clr) m_ptr = 0;
            else if (m_acc) m_ptr = m_last ? 0 : m_ptr + 1;
            if (ld_valid && int'(ld_addr) < N_GROUPS) m_bias[ld_addr] = ld_data;
            if (grp_clr) begin
                m_groups = (cfg_groups == 0 || int'(cfg_groups) > N_GROUPS) ?
                           N_GROUPS : int'(cfg_groups);
                m_relu   = cfg_relu;
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    // All tasks start and end one time unit after a rising edge.
    task automatic do_clr(input int groups, input logic relu);
        cfg_groups = (GRP_W + 1)'(groups);
        cfg_relu   = relu;
        grp_clr    = 1'b1;
        @(posedge clk); #1;
        grp_clr    = 1'b0;
    endtask

    task automatic load_row(input int addr, input logic [ROW_W-1:0] row);
        ld_valid = 1'b1;
        ld_addr  = GRP_W'(addr);
        ld_data  = row;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic send(input logic [ROW_W-1:0] d);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string name, input logic [ROW_W-1:0] exp_data,
                               input logic [GRP_W-1:0] exp_grp);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_valid"}, ok, 1'b1);
        check({name, "_data"}, out_data, exp_data);
        check({name, "_grp"}, out_grp, exp_grp);
        @(posedge clk); #1;
    endtask

    typedef struct {
        string            name;
        logic [DATA_W-1:0] bias;
        logic [DATA_W-1:0] din;
        logic              relu;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t             vecs[8];
    int               exp_grp[7] = '{0, 1, 2, 0, 1, 2, 0};
    bit               exp_wrap[7] = '{0, 0, 1, 0, 0, 1, 0};
    int               clr_vals[2] = '{0, 12};
    logic [ROW_W-1:0] row_a, row_b, exp_a, exp_b, held, r0, r1, r2, r2n, d;

    initial begin
        vecs[0] = '{"basic_add",   18'h00090, 18'h00010, 1'b0, 18'h000A0};
        vecs[1] = '{"sat_pos",     18'h1FFFF, 18'h00001, 1'b0, 18'h1FFFF};
        vecs[2] = '{"sat_neg",     18'h20000, 18'h3FFFF, 1'b0, 18'h20000};
        vecs[3] = '{"sat_neg_relu",18'h20000, 18'h3FFFF, 1'b1, 18'h00000};
        vecs[4] = '{"neg_result",  18'h3FFF0, 18'h00005, 1'b0, 18'h3FFF5};
        vecs[5] = '{"neg_relu",    18'h3FFF0, 18'h00005, 1'b1, 18'h00000};
        vecs[6] = '{"sat_pos_big", 18'h10000, 18'h10000, 1'b0, 18'h1FFFF};
        vecs[7] = '{"pos_relu",    18'h00005, 18'h3FFFE, 1'b1, 18'h00003};

        rst_n      = 1'b0;
        cfg_groups = '0;
        cfg_relu   = 1'b0;
        grp_clr    = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_grp", out_grp, '0);
        check("rst_grp_wrap", grp_wrap, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Arithmetic table
        for (int i = 0; i < 8; i++) begin
            do_clr(1, vecs[i].relu);
            load_row(0, rep(vecs[i].bias));
            send(rep(vecs[i].din));
            expect_beat(vecs[i].name, rep(vecs[i].exp), '0);
        end

        // Group sequence with cfg_groups=3
        do_clr(3, 1'b0);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = rand_row();
            @(negedge clk);
            check("seq_wrap", grp_wrap, exp_wrap[k]);
            if (k > 0) check("seq_grp", out_grp, GRP_W'(exp_grp[k-1]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("seq_grp_last", out_grp, GRP_W'(exp_grp[6]));
        @(posedge clk); #1;

        // Out-of-range group counts latch as N_GROUPS
        for (int c = 0; c < 2; c++) begin
            do_clr(clr_vals[c], 1'b0);
            for (int k = 0; k < N_GROUPS; k++) begin
                in_valid = 1'b1;
                in_data  = rand_row();
                @(negedge clk);
                check("cfg_clamp_wrap", grp_wrap, k == N_GROUPS - 1);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            @(posedge clk); #1;
        end

        // Backpressure: one beat held for 5 cycles, next accepted on release
        do_clr(1, 1'b0);
        r0 = rand_row();
        load_row(0, r0);
        row_a = rand_row();
        row_b = rand_row();
        exp_a = model_row(row_a, r0, 1'b0);
        exp_b = model_row(row_b, r0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = row_a;
        @(negedge clk);
        check("stall_first_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_data = row_b;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_hold", out_data, exp_a);
            @(posedge clk); #1;
        end
        held      = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", in_ready, 1'b1);
        check("release_data", out_data, exp_a);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_next_valid", out_valid, 1'b1);
        check("release_next_data", out_data, exp_b);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_no_dup", out_valid, 1'b0);
        @(posedge clk); #1;

        // Same-cycle write and use of row 2
        do_clr(3, 1'b0);
        r0  = rand_row();
        r1  = rand_row();
        r2  = rand_row();
        r2n = rand_row();
        load_row(0, r0);
        load_row(1, r1);
        load_row(2, r2);
        send('0);
        expect_beat("rw_g0", r0, 3'd0);
        send('0);
        expect_beat("rw_g1", r1, 3'd1);
        in_valid = 1'b1;
        in_data  = '0;
        ld_valid = 1'b1;
        ld_addr  = 3'd2;
        ld_data  = r2n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ld_valid = 1'b0;
        expect_beat("rw_g2_old", r2, 3'd2);
        send('0);
        expect_beat("rw_g0b", r0, 3'd0);
        send('0);
        expect_beat("rw_g1b", r1, 3'd1);
        send('0);
        expect_beat("rw_g2_new", r2n, 3'd2);

        // Randomised stream checked by the model
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 1) == 1);
            in_data    = rand_row();
            out_ready  = ($urandom_range(0, 3) != 0);
            ld_valid   = ($urandom_range(0, 4) == 0);
            ld_addr    = GRP_W'($urandom_range(0, N_GROUPS - 1));
            ld_data    = rand_row();
            grp_clr    = ($urandom_range(0, 39) == 0);
            cfg_groups = (GRP_W + 1)'($urandom_range(0, 15));
            cfg_relu   = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        ld_valid  = 1'b0;
        grp_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset while a beat is pending
        out_ready = 1'b0;
        send(rand_row());
        @(negedge clk);
        check("midrst_pending", out_valid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_grp", out_grp, '0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int g = 0; g < N_GROUPS; g++) begin
            d = rand_row();
            send(d);
            expect_beat("midrst_zero_bias", d, GRP_W'(g));
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
